// File: rtl/sr_by_d_pkg.sv
// Shared encodings for the sr_by_d flip-flop bank.
package sr_by_d_pkg;

  typedef enum logic [1:0] {
    MODE_SR = 2'b00,
    MODE_JK = 2'b01,
    MODE_T  = 2'b10,
    MODE_D  = 2'b11
  } mode_e;

  localparam int POL_HOLD = 0;
  localparam int POL_SET  = 1;
  localparam int POL_RST  = 2;

endpackage

// File: rtl/sr_by_d_ff_next_cell.sv
// Single-bit next-state decoder: picks the D input for one storage bit.
import sr_by_d_pkg::*;

module ff_next_cell #(
  parameter int SR_POLICY = POL_HOLD
) (
  input  logic [1:0] mode,
  input  logic       s,
  input  logic       r,
  input  logic       q,
  output logic       d,
  output logic       ill
);

  always_comb begin
    d   = q;
    ill = 1'b0;
    case (mode_e'(mode))
      MODE_SR: begin
        case ({s, r})
          2'b01:   d = 1'b0;
          2'b10:   d = 1'b1;
          2'b11: begin
            ill = 1'b1;
            if (SR_POLICY == POL_SET)      d = 1'b1;
            else if (SR_POLICY == POL_RST) d = 1'b0;
            else                           d = q;
          end
          default: d = q;
        endcase
      end
      MODE_JK: begin
        case ({s, r})
          2'b01:   d = 1'b0;
          2'b10:   d = 1'b1;
          2'b11:   d = ~q;
          default: d = q;
        endcase
      end
      MODE_T:  d = s ? ~q : q;
      MODE_D:  d = s;
      default: d = q;
    endcase
  end

endmodule

// File: rtl/sr_by_d.sv
// SR/JK/T/D flip-flop bank on plain D storage, with S=R=1 monitoring.
import sr_by_d_pkg::*;

module sr_by_d #(
  parameter int WIDTH     = 8,
  parameter int SR_POLICY = POL_HOLD,
  parameter int CNT_W     = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic [1:0]       mode,
  input  logic [WIDTH-1:0] s,
  input  logic [WIDTH-1:0] r,
  input  logic             clr_err,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] qbar,
  output logic [WIDTH-1:0] illegal,
  output logic             illegal_pulse,
  output logic [CNT_W-1:0] err_cnt
);

  logic [WIDTH-1:0] q_reg;
  logic [WIDTH-1:0] d_vec;
  logic [WIDTH-1:0] ill_raw;
  logic [WIDTH-1:0] ill_vec;
  logic             any_ill;

  for (genvar i = 0; i < WIDTH; i++) begin : g_cell
    ff_next_cell #(.SR_POLICY(SR_POLICY)) u_cell (
      .mode (mode),
      .s    (s[i]),
      .r    (r[i]),
      .q    (q_reg[i]),
      .d    (d_vec[i]),
      .ill  (ill_raw[i])
    );
  end

  assign ill_vec = en ? ill_raw : '0;
  assign any_ill = |ill_vec;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q_reg         <= '0;
      illegal       <= '0;
      illegal_pulse <= 1'b0;
      err_cnt       <= '0;
    end else begin
      if (en) q_reg <= d_vec;
      illegal_pulse <= any_ill;
      // A fresh illegal event in the clearing cycle survives the clear.
      if (clr_err) begin
        illegal <= ill_vec;
        err_cnt <= any_ill ? CNT_W'(1) : '0;
      end else begin
        illegal <= illegal | ill_vec;
        if (any_ill && (err_cnt != {CNT_W{1'b1}}))
          err_cnt <= err_cnt + CNT_W'(1);
      end
    end
  end

  assign q    = q_reg;
  assign qbar = ~q_reg;

endmodule

// File: tb/tb_sr_by_d.sv
// Directed bench for sr_by_d: three instances differing in SR_POLICY / CNT_W.
module tb_sr_by_d;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       en;
  logic [1:0] mode;
  logic [7:0] s, r;
  logic       clr_err;

  logic [7:0] q0, qb0, il0, q1, qb1, il1, q2, qb2, il2;
  logic       pl0, pl1, pl2;
  logic [7:0] cnt0, cnt2;
  logic [2:0] cnt1;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  sr_by_d #(.WIDTH(8), .SR_POLICY(0), .CNT_W(8)) u_p0 (
    .clk(clk), .rst_n(rst_n), .en(en), .mode(mode), .s(s), .r(r), .clr_err(clr_err),
    .q(q0), .qbar(qb0), .illegal(il0), .illegal_pulse(pl0), .err_cnt(cnt0));
  sr_by_d #(.WIDTH(8), .SR_POLICY(1), .CNT_W(3)) u_p1 (
    .clk(clk), .rst_n(rst_n), .en(en), .mode(mode), .s(s), .r(r), .clr_err(clr_err),
    .q(q1), .qbar(qb1), .illegal(il1), .illegal_pulse(pl1), .err_cnt(cnt1));
  sr_by_d #(.WIDTH(8), .SR_POLICY(2), .CNT_W(8)) u_p2 (
    .clk(clk), .rst_n(rst_n), .en(en), .mode(mode), .s(s), .r(r), .clr_err(clr_err),
    .q(q2), .qbar(qb2), .illegal(il2), .illegal_pulse(pl2), .err_cnt(cnt2));

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic e, input logic [1:0] m, input logic [7:0] sv, input logic [7:0] rv);
    en = e; mode = m; s = sv; r = rv;
  endtask

  initial begin
    rst_n = 1'b0; clr_err = 1'b0;
    drive(1'b0, 2'b00, 8'h00, 8'h00);
    repeat (2) step();
    chk("rst_q", q0, 8'h00);
    chk("rst_qbar", qb0, 8'hFF);
    chk("rst_ill", il0, 8'h00);
    chk("rst_pulse", pl0, 1'b0);
    chk("rst_cnt", cnt0, 8'h00);
    #3 rst_n = 1'b1;

    // Load A5, then reset mid-cycle: must clear immediately.
    drive(1'b1, 2'b11, 8'hA5, 8'h00);
    step();
    chk("d_a5", q0, 8'hA5);
    #2 rst_n = 1'b0;
    #1;
    chk("async_q", q0, 8'h00);
    chk("async_qbar", qb1, 8'hFF);
    chk("async_cnt", cnt0, 8'h00);
    step();
    chk("rst_hold_q", q2, 8'h00);
    #3 rst_n = 1'b1;

    drive(1'b1, 2'b00, 8'h0F, 8'hF0);
    step();
    chk("sr_set_rst", q0, 8'h0F);
    drive(1'b1, 2'b00, 8'h00, 8'h00);
    step();
    chk("sr_hold", q0, 8'h0F);
    chk("sr_no_ill", il0, 8'h00);

    // SR illegal from q=02 on bits 1:0.
    drive(1'b1, 2'b11, 8'h02, 8'h00);
    step();
    drive(1'b1, 2'b00, 8'h03, 8'h03);
    step();
    chk("ill_q_pol1", q1, 8'h03);
    chk("ill_q_pol0", q0, 8'h02);
    chk("ill_q_pol2", q2, 8'h00);
    chk("ill_flag", il1, 8'h03);
    chk("ill_pulse", pl1, 1'b1);
    chk("ill_cnt1", cnt1, 3'd1);
    chk("ill_cnt0", cnt0, 8'd1);
    drive(1'b1, 2'b00, 8'h00, 8'h00);
    step();
    chk("pulse_drop", pl1, 1'b0);
    chk("ill_sticky", il0, 8'h03);
    chk("cnt_keep", cnt1, 3'd1);

    clr_err = 1'b1; en = 1'b0;
    step();
    clr_err = 1'b0;
    chk("clr_ill", il0, 8'h00);
    chk("clr_cnt", cnt0, 8'h00);
    chk("clr_pulse", pl0, 1'b0);

    drive(1'b1, 2'b11, 8'h55, 8'h00);
    step();
    drive(1'b1, 2'b01, 8'hFF, 8'hFF);
    step();
    chk("jk_tog1", q0, 8'hAA);
    step();
    chk("jk_tog2", q0, 8'h55);
    chk("jk_no_ill", il0, 8'h00);
    chk("jk_no_pulse", pl0, 1'b0);

    drive(1'b1, 2'b11, 8'h00, 8'h00);
    step();
    drive(1'b1, 2'b10, 8'h01, 8'hFF);
    step(); chk("t1", q0, 8'h01);
    step(); chk("t2", q0, 8'h00);
    step(); chk("t3", q0, 8'h01);
    step(); chk("t4", q0, 8'h00);
    chk("t_no_ill", il0, 8'h00);

    // Saturation: 10 illegal cycles; 3-bit counter stops at 7.
    drive(1'b1, 2'b00, 8'hFF, 8'hFF);
    for (int i = 1; i <= 10; i++) begin
      step();
      chk($sformatf("sat_cnt1_%0d", i), cnt1, (i > 7) ? 7 : i);
    end
    chk("nosat_cnt0", cnt0, 8'd10);
    chk("sat_q_pol1", q1, 8'hFF);
    chk("sat_q_pol0", q0, 8'h00);

    clr_err = 1'b1;
    drive(1'b1, 2'b00, 8'h04, 8'h04);
    step();
    clr_err = 1'b0;
    chk("clrset_ill", il1, 8'h04);
    chk("clrset_cnt1", cnt1, 3'd1);
    chk("clrset_cnt0", cnt0, 8'd1);
    chk("clrset_pulse", pl0, 1'b1);

    drive(1'b0, 2'b00, 8'hFF, 8'hFF);
    step();
    chk("en0_q1", q1, 8'hFF);
    chk("en0_q2", q2, 8'h00);
    chk("en0_ill", il2, 8'h04);
    chk("en0_cnt", cnt2, 8'd1);
    chk("en0_pulse", pl2, 1'b0);

    drive(1'b1, 2'b11, 8'h3C, 8'hFF);
    step();
    chk("d_q", q1, 8'h3C);
    chk("d_qbar", qb1, 8'hC3);
    chk("d_no_ill", il1, 8'h04);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/sr_by_d.md
Name: sr_by_d

Overview:
- Multi-bit SR/JK/T/D flip-flop bank. All storage is plain D registers; next-state logic per bit is decoded from (s, r, mode).
- Complements the existing D-from-SR conversion block: here SR semantics are built on D storage.
- Adds deterministic S=R=1 handling in place of X propagation, plus illegal-input monitoring (sticky flags, saturating counter).
- Used as the reference flop bank for the flip-flop-conversion test suites and as a status/flag register in later days.

Parameters:
- WIDTH, 8, number of independent flip-flop bits
- SR_POLICY, 0, S=R=1 resolution in SR mode: 0 hold, 1 set-dominant, 2 reset-dominant
- CNT_W, 8, width of the illegal-event counter

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- en  input  1  update enable; 0 holds all state and suppresses illegal detection
- mode  input  2  00 SR, 01 JK, 10 T (s used as T, r ignored), 11 D (s used as D, r ignored)
- s  input  WIDTH  set / J / T / D per bit
- r  input  WIDTH  reset / K per bit
- clr_err  input  1  synchronous clear of illegal flags and counter
- q  output  WIDTH  flip-flop state
- qbar  output  WIDTH  always the exact complement of q, including during reset
- illegal  output  WIDTH  sticky per-bit flag: S=R=1 seen in SR mode
- illegal_pulse  output  1  registered; high for one cycle after any bit was illegal
- err_cnt  output  CNT_W  saturating count of cycles with at least one illegal bit

Behaviour:
- Reset (rst_n=0, asynchronous, any time): q=0, qbar=all ones, illegal=0, illegal_pulse=0, err_cnt=0. Release is synchronous to the next rising clk edge.
- Latency: q is updated at the first rising edge sampling en=1; inputs are sampled at that edge. qbar is derived from the same registered value (never a separate register that can diverge).
- en=0: q holds, no illegal detection, illegal_pulse=0 next cycle. clr_err still acts.
- SR mode, per bit:
  - 00 hold; 01 q=0; 10 q=1
  - 11 resolved by SR_POLICY (hold / 1 / 0) and marks the bit illegal
  - X is never produced
- JK mode: 00 hold, 01 q=0, 10 q=1, 11 toggle; never illegal.
- T mode: s[i]=1 toggles, s[i]=0 holds.
- D mode: q = s.
- mode is sampled each edge; a change takes effect on the same edge, with no pipeline state carried between modes.
- Illegal tracking (SR mode and en=1 only):
  - illegal[i] is set at the edge where s[i]&r[i]=1.
  - illegal_pulse = OR of those bits, registered.
  - err_cnt increments by 1 per such cycle, regardless of how many bits are illegal, and saturates at 2^CNT_W-1 (no wrap).
- clr_err with a simultaneous new illegal event: set wins.
  - illegal = only the new bits.
  - err_cnt = 1.
  - illegal_pulse = 1.
- clr_err alone: illegal=0, err_cnt=0, illegal_pulse=0 next cycle.
- Reset mid-operation discards all in-flight updates; nothing resumes after release.

Decomposition:
- Shared package sr_by_d_pkg:
  - mode encodings MODE_SR/MODE_JK/MODE_T/MODE_D
  - policy constants POL_HOLD/POL_SET/POL_RST
- One natural sub-module: ff_next_cell, a combinational single-bit next-state decoder generated WIDTH times.
- The top module holds the q register, the illegal flags, the pulse and the counter.

Test Plan:
- Reset: assert rst_n=0 mid-clock with q=8'hA5 -> q=8'h00, qbar=8'hFF immediately; err_cnt=0.
- SR mode, en=1, s=8'h0F, r=8'hF0 -> q=8'h0F after one edge. Then s=r=0 -> q holds 8'h0F.
- SR illegal, SR_POLICY=1, q=0, s=r=8'h03 -> q=8'h03, illegal=8'h03, illegal_pulse=1 for one cycle, err_cnt=1. Repeat with POLICY 0 -> q unchanged; with POLICY 2 -> q bits 0.
- JK with s=r=8'hFF from q=8'h55 -> q=8'hAA, then 8'h55; illegal stays 0. T mode with s=8'h01 for 4 edges -> q[0] toggles 1,0,1,0.
- Saturation: CNT_W=3, 10 consecutive illegal cycles -> err_cnt stops at 7. clr_err together with an illegal on bit 2 -> illegal=8'h04, err_cnt=1.
- en=0 with s=r=8'hFF in SR mode -> q, illegal and err_cnt unchanged. D mode with s=8'h3C -> q=8'h3C, qbar=8'hC3.
